accumulator_datapath: RTL and testbench

Execution datapath on the consuming end of the two-phase controller enable interface. Captures an operand into register A on `enA`, latches an ALU opcode on `enALU`, and commits the ALU result of (C op A) into accumulator C on `enC`. Also provides a registered flags word, a one-cycle result strobe, and a sticky protocol checker that flags enable sequences the controller must never produce.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_core.sv | 66 ++++++
 rtl/accumulator_datapath.sv | 105 ++++++++++
 tb/tb_accumulator_datapath.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and flag-word bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_PASS = 3'b101,
        OP_SHL  = 3'b110,
        OP_SHR  = 3'b111
    } alu_op_t;

    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned FLAG_Z  = 3;
    localparam int unsigned FLAG_N  = 2;
    localparam int unsigned FLAG_CY = 1;
    localparam int unsigned FLAG_V  = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result = C op A, plus {Z, N, CY, V}.
// CY is carry for ADD, borrow for SUB, the shifted-out bit for shifts.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]  c_i,
    input  logic [WIDTH-1:0]  a_i,
    input  alu_op_t           op_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [FLAG_W-1:0] flags_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           cy;
    logic           v;

    assign sum  = {1'b0, c_i} + {1'b0, a_i};
    assign diff = {1'b0, c_i} - {1'b0, a_i};

    // Opcode decode: result, carry/borrow and signed overflow
    always_comb begin
        result_o = '0;
        cy       = 1'b0;
        v        = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[WIDTH-1:0];
                cy       = sum[WIDTH];
                v        = (c_i[WIDTH-1] == a_i[WIDTH-1]) &&
                           (sum[WIDTH-1] != c_i[WIDTH-1]);
            end
            OP_SUB: begin
                result_o = diff[WIDTH-1:0];
                cy       = diff[WIDTH];
                v        = (c_i[WIDTH-1] != a_i[WIDTH-1]) &&
                           (diff[WIDTH-1] != c_i[WIDTH-1]);
            end
            OP_AND:  result_o = c_i & a_i;
            OP_OR:   result_o = c_i | a_i;
            OP_XOR:  result_o = c_i ^ a_i;
            OP_PASS: result_o = a_i;
            OP_SHL: begin
                result_o = {c_i[WIDTH-2:0], 1'b0};
                cy       = c_i[WIDTH-1];
            end
            OP_SHR: begin
                result_o = {1'b0, c_i[WIDTH-1:1]};
                cy       = c_i[0];
            end
            default: result_o = '0;
        endcase
    end

    // Flag word assembly from the selected result
    always_comb begin
        flags_o          = '0;
        flags_o[FLAG_Z]  = (result_o == '0);
        flags_o[FLAG_N]  = result_o[WIDTH-1];
        flags_o[FLAG_CY] = cy;
        flags_o[FLAG_V]  = v;
    end

endmodule

// File: rtl/accumulator_datapath.sv
// Accumulator datapath: A/opcode/C registers, result strobe, sticky
// protocol checker. Define ALU_FLAGS_EN to build the registered flags
// word; otherwise flags is tied to zero.
module accumulator_datapath
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              CLKb,
    input  logic              RESETb,
    input  logic              enA,
    input  logic              enALU,
    input  logic              enC,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [2:0]        op_in,
    output logic [WIDTH-1:0]  acc_out,
    output logic [WIDTH-1:0]  a_out,
    output logic [FLAG_W-1:0] flags,
    output logic              result_valid,
    output logic              proto_err
);

    logic [WIDTH-1:0]  a_q,     a_d;
    logic [WIDTH-1:0]  c_q,     c_d;
    alu_op_t           op_q,    op_d;
    logic              rv_q,    rv_d;
    logic              perr_q,  perr_d;
    logic              fresh_q, fresh_d;
    logic              violation;

    logic [WIDTH-1:0]  alu_result;
    logic [FLAG_W-1:0] alu_flags;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu (
        .c_i      (c_q),
        .a_i      (a_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    // Illegal enable combinations: commit alongside a load, or commit on a stale A
    assign violation = (enC && (enA || enALU)) || (enC && !fresh_q && !enA);

    // Next-state: each register loads independently from pre-edge values
    always_comb begin
        a_d     = enA   ? data_in          : a_q;
        op_d    = enALU ? alu_op_t'(op_in) : op_q;
        c_d     = enC   ? alu_result       : c_q;
        rv_d    = enC;
        perr_d  = perr_q || violation;
        fresh_d = enA ? 1'b1 : (enC ? 1'b0 : fresh_q);
    end

    // State registers
    always_ff @(posedge CLKb or negedge RESETb) begin
        if (!RESETb) begin
            a_q     <= '0;
            op_q    <= OP_ADD;
            c_q     <= '0;
            rv_q    <= 1'b0;
            perr_q  <= 1'b0;
            fresh_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            op_q    <= op_d;
            c_q     <= c_d;
            rv_q    <= rv_d;
            perr_q  <= perr_d;
            fresh_q <= fresh_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [FLAG_W-1:0] flags_q, flags_d;

    // Flags follow the ALU only on a commit
    always_comb begin
        flags_d = enC ? alu_flags : flags_q;
    end

    // Flags register
    always_ff @(posedge CLKb or negedge RESETb) begin
        if (!RESETb) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    logic unused_alu_flags;
    assign unused_alu_flags = ^alu_flags;
    assign flags            = '0;
`endif

    assign acc_out      = c_q;
    assign a_out        = a_q;
    assign result_valid = rv_q;
    assign proto_err    = perr_q;

endmodule

// File: tb/tb_accumulator_datapath.sv
// Directed + random bench for accumulator_datapath with a result scoreboard.
module tb_accumulator_datapath;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                           XOR_ = 3'b100, PASS = 3'b101, SHL = 3'b110, SHR = 3'b111;

    logic       CLKb = 1'b0;
    logic       RESETb = 1'b0;
    logic       enA = 1'b0, enALU = 1'b0, enC = 1'b0;
    logic [7:0] data_in = '0;
    logic [2:0] op_in = '0;
    logic [7:0] acc_out, a_out;
    logic [3:0] flags;
    logic       result_valid, proto_err;

    accumulator_datapath #(
        .WIDTH (8)
    ) dut (
        .CLKb         (CLKb),
        .RESETb       (RESETb),
        .enA          (enA),
        .enALU        (enALU),
        .enC          (enC),
        .data_in      (data_in),
        .op_in        (op_in),
        .acc_out      (acc_out),
        .a_out        (a_out),
        .flags        (flags),
        .result_valid (result_valid),
        .proto_err    (proto_err)
    );

    always #5 CLKb = ~CLKb;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    // reference model state
    logic [7:0] m_a, m_c;
    logic [2:0] m_op;
    logic [3:0] m_flags;
    logic       m_fresh, m_perr, m_rv;
    logic [11:0] exp_q[$];

`ifdef ALU_FLAGS_EN
    localparam bit FLAGS_BUILT = 1'b1;
`else
    localparam bit FLAGS_BUILT = 1'b0;
`endif

    // returns {Z, N, CY, V, result}
    function automatic logic [11:0] ref_alu(logic [7:0] c, logic [7:0] a, logic [2:0] op);
        int unsigned s;
        int sc, sa, ss;
        logic [7:0] r;
        bit cy, v;
        sc = int'($signed(c));
        sa = int'($signed(a));
        cy = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (op)
            ADD: begin
                s  = c + a;
                r  = s[7:0];
                cy = (s > 255);
                ss = sc + sa;
                v  = (ss > 127) || (ss < -128);
            end
            SUB: begin
                r  = c - a;
                cy = (c < a);
                ss = sc - sa;
                v  = (ss > 127) || (ss < -128);
            end
            AND_: r = c & a;
            OR_:  r = c | a;
            XOR_: r = c ^ a;
            PASS: r = a;
            SHL: begin r = c << 1; cy = c[7]; end
            default: begin r = c >> 1; cy = c[0]; end
        endcase
        return {(r == 8'h00), r[7], cy, v, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_a = '0; m_c = '0; m_op = '0; m_flags = '0;
        m_fresh = 1'b0; m_perr = 1'b0; m_rv = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_all(input string tag);
        logic [11:0] e;
        check({tag, ".acc"},   32'(acc_out),      32'(m_c));
        check({tag, ".a"},     32'(a_out),        32'(m_a));
        check({tag, ".rv"},    32'(result_valid), 32'(m_rv));
        check({tag, ".perr"},  32'(proto_err),    32'(m_perr));
        check({tag, ".flags"}, 32'(flags),        FLAGS_BUILT ? 32'(m_flags) : 32'h0);
        if (m_rv) begin
            if (exp_q.size() == 0) begin
                check({tag, ".sb_empty"}, 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check({tag, ".sb_acc"},   32'(acc_out), 32'(e[7:0]));
                check({tag, ".sb_flags"}, 32'(flags),   FLAGS_BUILT ? 32'(e[11:8]) : 32'h0);
            end
        end
    endtask

    // one clock with the given enables; model updates from pre-edge values
    task automatic step(input bit ea, input bit ealu, input bit ec,
                        input logic [7:0] d, input logic [2:0] op, input string tag);
        logic [11:0] res;
        enA = ea; enALU = ealu; enC = ec; data_in = d; op_in = op;
        res = ref_alu(m_c, m_a, m_op);
        if (ec) exp_q.push_back(res);
        @(posedge CLKb);
        if (ec && (ea || ealu)) m_perr = 1'b1;
        if (ec && !m_fresh && !ea) m_perr = 1'b1;
        if (ec) begin m_c = res[7:0]; m_flags = res[11:8]; end
        m_fresh = ea ? 1'b1 : (ec ? 1'b0 : m_fresh);
        if (ea) m_a = d;
        if (ealu) m_op = op;
        m_rv = ec;
        #1;
        enA = 1'b0; enALU = 1'b0; enC = 1'b0;
        check_all(tag);
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic reset_pulse(input string tag);
        #2;
        RESETb = 1'b0;
        #1;
        model_clear();
        check_all(tag);
        #1;
        RESETb = 1'b1;
    endtask

    task automatic legal(input logic [7:0] d, input logic [2:0] op, input string tag);
        step(1, 1, 0, d, op, {tag, ".ld"});
        step(0, 0, 1, 8'h00, 3'b000, {tag, ".cm"});
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge CLKb);
        #1;
        check_all("reset_init");
        RESETb = 1'b1;

        // basic legal commit, then strobe drops
        legal(8'h05, ADD, "add5");
        step(0, 0, 0, 8'h00, ADD, "idle1");

        // asynchronous reset mid-cycle clears everything
        reset_pulse("async_rst");
        legal(8'h05, ADD, "post_rst");

        // carry / overflow
        legal(8'h7A, ADD, "c7f");
        legal(8'h01, ADD, "ovf");
        legal(8'h7F, ADD, "cff");
        legal(8'h01, ADD, "wrap");

        // subtract borrow, then logical shift right
        legal(8'h03, PASS, "c03");
        legal(8'h05, SUB, "borrow");
        legal(8'h00, SHR, "shr");
        legal(8'h0F, AND_, "and");
        legal(8'hA0, OR_, "or");
        legal(8'hFF, XOR_, "xor");

        // stale-operand commit still updates C
        legal(8'h81, PASS, "c81");
        step(0, 1, 0, 8'h00, SHL, "alu_only");
        step(0, 0, 1, 8'h00, ADD, "stale_shl");
        step(0, 0, 0, 8'h00, ADD, "idle2");
        reset_pulse("rst_b");

        // enA together with enC, error sticks through legal traffic
        step(0, 1, 0, 8'h00, ADD, "pre_a");
        step(1, 0, 1, 8'h11, ADD, "viol_a");
        legal(8'h22, SUB, "sticky1");
        legal(8'h33, XOR_, "sticky2");
        reset_pulse("rst_a");

        // first commit after reset without a load
        step(0, 0, 1, 8'h00, ADD, "stale_rst");
        reset_pulse("rst_c");

        // back-to-back commits
        step(1, 1, 0, 8'h40, ADD, "b2b.ld");
        step(0, 0, 1, 8'h00, ADD, "b2b.c1");
        step(0, 0, 1, 8'h00, ADD, "b2b.c2");
        step(0, 0, 1, 8'h00, ADD, "b2b.c3");
        reset_pulse("rst_d");

        // random enable traffic
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 3'($urandom), "rand");
            if (($urandom % 16) == 0) reset_pulse("rand_rst");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
